vga_key_highlight_controller: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller. It generates its own H/V timing and streams linear frame-buffer addresses to an external image memory. Each returned BGR pixel is recoloured against NUM_KEYS key colours: a key pixel is shown dim, or bright while its key is highlighted. Highlights are requested by game logic and run for a fixed number of whole frames, followed by a dark gap, under a frame-synchronous FSM.

---
 rtl/vga_key_highlight_controller.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_vga_key_highlight_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_key_highlight_controller.sv
`timescale 1ns/1ps
// vga_key_highlight_controller
//
// Purpose:
//   Generates VGA H/V timing, streams linear frame-buffer read addresses to an
//   external image memory and recolours each returned BGR pixel against a set
//   of key colours. A pixel matching key k is shown in its dim colour, or in
//   its bright colour while key k is being highlighted. Highlights are
//   requested by game logic and run for HOLD_FRAMES whole frames followed by
//   GAP_FRAMES forced-dim frames.
//
// Ports:
//   iVGA_CLK    pixel clock
//   iRST        asynchronous active-high reset
//   iHL_valid   one-cycle highlight request
//   iHL_code    requested key, 1..NUM_KEYS selects key 0..NUM_KEYS-1
//   oHL_busy    highlight sequencer is not idle
//   oMEM_ADDR   image memory read address
//   iPIX_BGR    image memory data, valid MEM_LAT clocks after the address
//   oBLANK_n    high during the visible area
//   oHS, oVS    active-low sync pulses
//   b_data, g_data, r_data   colour outputs (BGR bits 23:16, 15:8, 7:0)
//
// All timing and colour outputs share a latency of MEM_LAT+1 clocks from the
// counter state that produced them.

module vga_key_highlight_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19,
    parameter int MEM_LAT  = 2,
    parameter int NUM_KEYS = 4,
    parameter int CODE_W   = 4,
    parameter logic [24*NUM_KEYS-1:0] KEY_BGR    = {24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF},
    parameter logic [24*NUM_KEYS-1:0] DIM_BGR    = {24'h404040, 24'h400000, 24'h004000, 24'h000040},
    parameter logic [24*NUM_KEYS-1:0] BRIGHT_BGR = {24'hFFFFFF, 24'hFF8080, 24'h80FF80, 24'h8080FF},
    parameter int HOLD_FRAMES = 30,
    parameter int GAP_FRAMES  = 6
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    input  logic              iHL_valid,
    input  logic [CODE_W-1:0] iHL_code,
    output logic              oHL_busy,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    input  logic [23:0]       iPIX_BGR,
    output logic              oBLANK_n,
    output logic              oHS,
    output logic              oVS,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int MAX_F   = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
    localparam int FCNT_W  = $clog2(MAX_F + 1);

    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [FCNT_W-1:0] GAP_LAST  = FCNT_W'(GAP_FRAMES - 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(NUM_KEYS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ON,
        ST_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Timing counters and address generator
    // ------------------------------------------------------------------
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              h_last, v_last;
    logic              frame_start;
    logic              visible;
    logic              hs_raw, vs_raw;

    always_comb begin
        h_last      = (h_cnt_q == H_LAST);
        v_last      = (v_cnt_q == V_LAST);
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
        visible     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_raw      = !((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                        (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC));
        vs_raw      = !((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                        (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC));

        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        // The address is cleared together with the counters wrapping, so it
        // already reads 0 during the frame_start cycle.
        if (h_last && v_last) begin
            addr_d = '0;
        end else if (visible) begin
            addr_d = addr_q + 1'b1;
        end else begin
            addr_d = addr_q;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign oMEM_ADDR = addr_q;

    // ------------------------------------------------------------------
    // Highlight sequencer
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              busy_q;
    logic              code_ok;
    logic              hl_raw;

    always_comb begin
        code_ok = (iHL_code != '0) && (iHL_code <= CODE_MAX);
        state_d = state_q;
        fcnt_d  = fcnt_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (iHL_valid && code_ok) begin
                    code_d  = iHL_code;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_d = ST_ON;
                    fcnt_d  = '0;
                end
            end
            ST_ON: begin
                if (frame_start) begin
                    if (fcnt_q == HOLD_LAST) begin
                        state_d = ST_GAP;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (frame_start) begin
                    if (fcnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = '0;
            end
        endcase
        // The frame_start pixel belongs to the frame the sequencer is moving
        // into, so the flag for the current counter state is taken from the
        // next state. This makes ON cover whole frames starting at pixel 0.
        hl_raw = (state_d == ST_ON);
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            code_q  <= code_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign oHL_busy = busy_q;

    // ------------------------------------------------------------------
    // Alignment pipeline. Bit i of each vector holds the value from i+1
    // clocks ago; bit MEM_LAT-1 lines up with iPIX_BGR, bit MEM_LAT with
    // the registered colour at the pins.
    // ------------------------------------------------------------------
    logic [MEM_LAT:0]   hs_pipe_q, vs_pipe_q, vis_pipe_q;
    logic [MEM_LAT-1:0] hl_pipe_q;
    logic               vis_al, hl_al;

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            vis_pipe_q <= '0;
            hl_pipe_q  <= '0;
        end else begin
            hs_pipe_q  <= {hs_pipe_q[MEM_LAT-1:0], hs_raw};
            vs_pipe_q  <= {vs_pipe_q[MEM_LAT-1:0], vs_raw};
            vis_pipe_q <= {vis_pipe_q[MEM_LAT-1:0], visible};
            hl_pipe_q  <= MEM_LAT'({hl_pipe_q, hl_raw});
        end
    end

    assign vis_al = vis_pipe_q[MEM_LAT-1];
    assign hl_al  = hl_pipe_q[MEM_LAT-1];

    // ------------------------------------------------------------------
    // Recolour
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_hit;
    logic [NUM_KEYS-1:0] key_lit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign key_hit[gi] = (iPIX_BGR == KEY_BGR[24*gi +: 24]);
            assign key_lit[gi] = hl_al && (code_q == CODE_W'(gi + 1));
        end
    endgenerate

    logic [23:0] pix_q, pix_d;
    logic        hit;

    always_comb begin
        pix_d = iPIX_BGR;
        hit   = 1'b0;
        // Duplicate key colours resolve to the lowest index.
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!hit && key_hit[k]) begin
                hit   = 1'b1;
                pix_d = key_lit[k] ? BRIGHT_BGR[24*k +: 24] : DIM_BGR[24*k +: 24];
            end
        end
        if (!vis_al) begin
            pix_d = '0;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign oHS      = hs_pipe_q[MEM_LAT];
    assign oVS      = vs_pipe_q[MEM_LAT];
    assign oBLANK_n = vis_pipe_q[MEM_LAT];
    assign b_data   = pix_q[23:16];
    assign g_data   = pix_q[15:8];
    assign r_data   = pix_q[7:0];

endmodule

// File: tb/tb_vga_key_highlight_controller.sv
`timescale 1ns/1ps
// Testbench for vga_key_highlight_controller on a tiny 14x8 raster.
// A behavioural model predicts every output on every cycle from the cycle
// count since reset release; a few literal expectations pin the model.

module tb_vga_key_highlight_controller;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 1;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 14
    localparam int VT = VA + VF + VSW + VB;   // 8
    localparam int FR = HT * VT;              // 112
    localparam int MLAT = 2;
    localparam int LAT = MLAT + 1;
    localparam int HOLD = 2;
    localparam int GAP = 1;
    localparam int AW = 6;

    // key 3 duplicates key 1 so the lowest-index rule is exercised
    localparam logic [95:0] KEYS    = {24'h00FF00, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    localparam logic [95:0] DIMS    = {24'h101010, 24'h100000, 24'h001000, 24'h000010};
    localparam logic [95:0] BRIGHTS = {24'hF0F0F0, 24'hF00000, 24'h00F000, 24'h0000F0};

    logic          clk;
    logic          iRST;
    logic          iHL_valid;
    logic [3:0]    iHL_code;
    logic          oHL_busy;
    logic [AW-1:0] oMEM_ADDR;
    logic [23:0]   iPIX_BGR;
    logic          oBLANK_n, oHS, oVS;
    logic [7:0]    b_data, g_data, r_data;

    vga_key_highlight_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .ADDR_W(AW), .MEM_LAT(MLAT), .NUM_KEYS(4), .CODE_W(4),
        .KEY_BGR(KEYS), .DIM_BGR(DIMS), .BRIGHT_BGR(BRIGHTS),
        .HOLD_FRAMES(HOLD), .GAP_FRAMES(GAP)
    ) dut (
        .iVGA_CLK(clk), .iRST(iRST),
        .iHL_valid(iHL_valid), .iHL_code(iHL_code), .oHL_busy(oHL_busy),
        .oMEM_ADDR(oMEM_ADDR), .iPIX_BGR(iPIX_BGR),
        .oBLANK_n(oBLANK_n), .oHS(oHS), .oVS(oVS),
        .b_data(b_data), .g_data(g_data), .r_data(r_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Colour tables for the model
    logic [23:0] key_tab [0:3];
    logic [23:0] dim_tab [0:3];
    logic [23:0] brt_tab [0:3];
    initial begin
        key_tab[0] = 24'h0000FF; key_tab[1] = 24'h00FF00; key_tab[2] = 24'hFF0000; key_tab[3] = 24'h00FF00;
        dim_tab[0] = 24'h000010; dim_tab[1] = 24'h001000; dim_tab[2] = 24'h100000; dim_tab[3] = 24'h101010;
        brt_tab[0] = 24'h0000F0; brt_tab[1] = 24'h00F000; brt_tab[2] = 24'hF00000; brt_tab[3] = 24'hF0F0F0;
    end

    // Image memory: contents change only while reset is held.
    logic [23:0] mem [0:63];
    logic [23:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem[oMEM_ADDR];
        rd2 <= rd1;
    end
    assign iPIX_BGR = rd2;

    // Cycle index since reset release
    int n;
    always @(posedge clk) begin
        if (iRST) n <= 0;
        else      n <= n + 1;
    end

    int errors = 0;
    int checks = 0;
    bit lit_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    function automatic logic [23:0] model_pix(input logic [23:0] p, input bit hl, input int code);
        for (int k = 0; k < 4; k++) begin
            if (p == key_tab[k]) return (hl && code == k + 1) ? brt_tab[k] : dim_tab[k];
        end
        return p;
    endfunction

    // Model state: the one accepted highlight request
    bit req_valid = 1'b0;
    int req_n, req_f, req_end, req_code;

    // Compare process: one full output check per cycle
    initial begin
        int pos, h, v, m, mp, mh, mv, f, e_addr;
        bit e_busy, e_hs, e_vs, e_bl, hl;
        logic [23:0] e_pix;
        forever begin
            @(negedge clk);
            if (iRST) begin
                req_valid = 1'b0;
                e_busy = 0; e_addr = 0; e_hs = 1; e_vs = 1; e_bl = 0; e_pix = '0;
            end else begin
                pos = n % FR; h = pos % HT; v = pos / HT;
                e_addr = (v < VA) ? v * HA + ((h < HA) ? h : HA) : HA * VA;
                e_busy = req_valid && (n >= req_n + 1) && (n <= req_end);
                m = n - LAT;
                if (m < 0) begin
                    e_hs = 1; e_vs = 1; e_bl = 0; e_pix = '0;
                end else begin
                    mp = m % FR; mh = mp % HT; mv = mp / HT; f = m / FR;
                    e_hs = !(mh >= HA + HF && mh < HA + HF + HSW);
                    e_vs = !(mv >= VA + VF && mv < VA + VF + VSW);
                    e_bl = (mh < HA) && (mv < VA);
                    hl = req_valid && (f >= req_f + 1) && (f <= req_f + HOLD);
                    e_pix = e_bl ? model_pix(mem[mv * HA + mh], hl, req_code) : 24'h0;
                end
            end
            chk("hs", 32'(oHS), 32'(e_hs));
            chk("vs", 32'(oVS), 32'(e_vs));
            chk("blank_n", 32'(oBLANK_n), 32'(e_bl));
            chk("busy", 32'(oHL_busy), 32'(e_busy));
            chk("addr", 32'(oMEM_ADDR), 32'(e_addr));
            chk("b", 32'(b_data), 32'(e_pix[23:16]));
            chk("g", 32'(g_data), 32'(e_pix[15:8]));
            chk("r", 32'(r_data), 32'(e_pix[7:0]));

            if (lit_on) begin
                case (n)
                    2:   chk("lit_blank_before_first", 32'(oBLANK_n), 32'd0);
                    3:   begin
                             chk("lit_first_blank_n", 32'(oBLANK_n), 32'd1);
                             chk("lit_first_dim_g", 32'(g_data), 32'h10);
                         end
                    7:   chk("lit_addr7", 32'(oMEM_ADDR), 32'd7);
                    8:   chk("lit_passthru", {8'h0, b_data, g_data, r_data}, 32'h123456);
                    10:  chk("lit_addr_hold", 32'(oMEM_ADDR), 32'd8);
                    13:  chk("lit_hs_low", 32'(oHS), 32'd0);
                    16:  chk("lit_hs_high", 32'(oHS), 32'd1);
                    50:  chk("lit_busy_pre", 32'(oHL_busy), 32'd0);
                    51:  chk("lit_busy_rise", 32'(oHL_busy), 32'd1);
                    60:  chk("lit_addr_end", 32'(oMEM_ADDR), 32'd32);
                    73:  chk("lit_vs_low", 32'(oVS), 32'd0);
                    101: chk("lit_vs_high", 32'(oVS), 32'd1);
                    112: chk("lit_addr_wrap", 32'(oMEM_ADDR), 32'd0);
                    115: chk("lit_bright_start", 32'(g_data), 32'hF0);
                    230: chk("lit_bright_kept", 32'(g_data), 32'hF0);
                    339: chk("lit_gap_dim", 32'(g_data), 32'h10);
                    448: chk("lit_busy_last", 32'(oHL_busy), 32'd1);
                    449: chk("lit_busy_drop", 32'(oHL_busy), 32'd0);
                    521: chk("lit_bad_code_idle", 32'(oHL_busy), 32'd0);
                    787: chk("lit_fs_req_not_on", 32'(g_data), 32'h10);
                    899: chk("lit_fs_req_on", 32'(g_data), 32'hF0);
                    default: ;
                endcase
            end

            if (!iRST && iHL_valid) begin
                if (iHL_code >= 4'd1 && iHL_code <= 4'd4 && !e_busy) begin
                    req_valid = 1'b1;
                    req_n     = n;
                    req_f     = n / FR;
                    req_end   = (req_f + HOLD + GAP + 1) * FR;
                    req_code  = int'(iHL_code);
                    $display("req n=%0d code=%0d accepted, on frames %0d..%0d", n, req_code, req_f + 1, req_f + HOLD);
                end else begin
                    $display("req n=%0d code=%0d dropped", n, iHL_code);
                end
            end
        end
    end

    task automatic wait_until(input int target);
        while (n < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int code);
        iHL_valid = 1'b1;
        iHL_code  = 4'(code);
        @(posedge clk);
        #1;
        iHL_valid = 1'b0;
        iHL_code  = 4'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        iRST = 1'b1;
        iHL_valid = 1'b0;
        iHL_code = 4'd0;
        for (int i = 0; i < 64; i++) mem[i] = 24'h00FF00;
        mem[5] = 24'h123456;
        repeat (4) @(posedge clk);
        #1;
        iRST = 1'b0;
        lit_on = 1'b1;

        wait_until(50);   pulse(2);
        wait_until(200);  pulse(3);
        wait_until(500);  pulse(0);
        wait_until(520);  pulse(5);
        wait_until(784);  pulse(2);
        wait_until(1240);
        lit_on = 1'b0;
        wait_until(1250); pulse(2);
        wait_until(12 * FR + 30);

        // Reset while ON: outputs must clear before any clock edge
        iRST = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_busy", 32'(oHL_busy), 32'd0);
        chk("rst_hs", 32'(oHS), 32'd1);
        chk("rst_vs", 32'(oVS), 32'd1);
        chk("rst_blank_n", 32'(oBLANK_n), 32'd0);
        chk("rst_addr", 32'(oMEM_ADDR), 32'd0);
        chk("rst_colour", {8'h0, b_data, g_data, r_data}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        iRST = 1'b0;
        wait_until(3);
        @(negedge clk);
        #2;
        chk("post_rst_dim", 32'(g_data), 32'h10);
        chk("post_rst_busy", 32'(oHL_busy), 32'd0);
        wait_until(2 * FR);

        // Randomised phase
        iRST = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) < 2) mem[i] = key_tab[$urandom_range(0, 3)];
            else                          mem[i] = 24'($urandom);
        end
        repeat (2) @(posedge clk);
        #1;
        iRST = 1'b0;
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(5, 200)) @(posedge clk);
            #1;
            if (it == 15) begin
                iRST = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                iRST = 1'b0;
            end
            pulse(int'($urandom_range(0, 6)));
        end
        repeat (200) @(posedge clk);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
